// File: rtl/boa_fetch_pkg.sv
// Shared fetch-path definitions for the instruction realigner: FSM encoding,
// halfword buffer depth and the RISC-V instruction-length test.
package boa_fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    ALIGN = 1'b1
  } align_state_t;

  localparam int HW_DEPTH = 4;

  // Only the two low bits of a halfword decide its instruction length.
  function automatic logic insn_is32(input logic [1:0] lowBits);
    return lowBits == 2'b11;
  endfunction

endpackage

// File: rtl/boa_insn_decomp.sv
// RV32C to RV32I expander: combinational, one 16-bit halfword in, one 32-bit
// instruction out, with an illegal flag for reserved or unsupported encodings.
module boa_insn_decomp #(
  parameter logic [31:0] ISA_MASK = 32'hffff_ffff
) (
  input  logic [15:0] i_hw,
  output logic [31:0] o_insn,
  output logic        o_ill
);

  logic [4:0]  w_rd, w_rs2, w_rdp, w_rs1p;
  logic [11:0] w_imm6;
  logic [20:0] w_jimm;
  logic [12:0] w_bimm;
  logic [9:0]  w_imm4spn, w_imm16sp;
  logic [6:0]  w_offLw;
  logic [7:0]  w_offLwsp, w_offSwsp;
  logic [2:0]  w_aluF3;

  assign w_rd      = i_hw[11:7];
  assign w_rs2     = i_hw[6:2];
  assign w_rdp     = {2'b01, i_hw[4:2]};
  assign w_rs1p    = {2'b01, i_hw[9:7]};
  assign w_imm6    = {{6{i_hw[12]}}, i_hw[12], i_hw[6:2]};
  assign w_jimm    = {{9{i_hw[12]}}, i_hw[12], i_hw[8], i_hw[10:9], i_hw[6], i_hw[7],
                      i_hw[2], i_hw[11], i_hw[5:3], 1'b0};
  assign w_bimm    = {{4{i_hw[12]}}, i_hw[12], i_hw[6:5], i_hw[2], i_hw[11:10], i_hw[4:3], 1'b0};
  assign w_imm4spn = {i_hw[10:7], i_hw[12:11], i_hw[5], i_hw[6], 2'b00};
  assign w_imm16sp = {i_hw[12], i_hw[4:3], i_hw[5], i_hw[2], i_hw[6], 4'b0000};
  assign w_offLw   = {i_hw[5], i_hw[12:10], i_hw[6], 2'b00};
  assign w_offLwsp = {i_hw[3:2], i_hw[12], i_hw[6:4], 2'b00};
  assign w_offSwsp = {i_hw[8:7], i_hw[12:9], 2'b00};

  always_comb begin
    w_aluF3 = 3'b000;
    case (i_hw[6:5])
      2'b01:   w_aluF3 = 3'b100;
      2'b10:   w_aluF3 = 3'b110;
      2'b11:   w_aluF3 = 3'b111;
      default: w_aluF3 = 3'b000;
    endcase
  end

  // Decode by quadrant (bits 1:0) then funct3 (bits 15:13).
  always_comb begin
    o_insn = 32'h0000_0000;
    o_ill  = 1'b0;
    case ({i_hw[1:0], i_hw[15:13]})
      5'b00_000: begin
        o_insn = {2'b00, w_imm4spn, 5'd2, 3'b000, w_rdp, 7'b0010011};
        o_ill  = (w_imm4spn == 10'd0);
      end
      5'b00_010: o_insn = {5'b0, w_offLw, w_rs1p, 3'b010, w_rdp, 7'b0000011};
      5'b00_110: o_insn = {5'b0, w_offLw[6:5], w_rdp, w_rs1p, 3'b010, w_offLw[4:0], 7'b0100011};
      5'b01_000: o_insn = {w_imm6, w_rd, 3'b000, w_rd, 7'b0010011};
      5'b01_001: o_insn = {w_jimm[20], w_jimm[10:1], w_jimm[11], w_jimm[19:12], 5'd1, 7'b1101111};
      5'b01_010: o_insn = {w_imm6, 5'd0, 3'b000, w_rd, 7'b0010011};
      5'b01_011: begin
        if (w_rd == 5'd2) begin
          o_insn = {{2{i_hw[12]}}, w_imm16sp, 5'd2, 3'b000, 5'd2, 7'b0010011};
          o_ill  = (w_imm16sp == 10'd0);
        end else begin
          o_insn = {{14{i_hw[12]}}, i_hw[12], i_hw[6:2], w_rd, 7'b0110111};
          o_ill  = ({i_hw[12], i_hw[6:2]} == 6'd0);
        end
      end
      5'b01_100: begin
        case (i_hw[11:10])
          2'b00: begin
            o_insn = {7'b0000000, i_hw[6:2], w_rs1p, 3'b101, w_rs1p, 7'b0010011};
            o_ill  = i_hw[12];
          end
          2'b01: begin
            o_insn = {7'b0100000, i_hw[6:2], w_rs1p, 3'b101, w_rs1p, 7'b0010011};
            o_ill  = i_hw[12];
          end
          2'b10:   o_insn = {w_imm6, w_rs1p, 3'b111, w_rs1p, 7'b0010011};
          default: begin
            o_insn = {1'b0, (i_hw[6:5] == 2'b00), 5'b0, w_rdp, w_rs1p, w_aluF3, w_rs1p, 7'b0110011};
            o_ill  = i_hw[12];
          end
        endcase
      end
      5'b01_101: o_insn = {w_jimm[20], w_jimm[10:1], w_jimm[11], w_jimm[19:12], 5'd0, 7'b1101111};
      5'b01_110, 5'b01_111:
        o_insn = {w_bimm[12], w_bimm[10:5], 5'd0, w_rs1p, 2'b00, i_hw[13], w_bimm[4:1], w_bimm[11], 7'b1100011};
      5'b10_000: begin
        o_insn = {7'b0, i_hw[6:2], w_rd, 3'b001, w_rd, 7'b0010011};
        o_ill  = i_hw[12];
      end
      5'b10_010: begin
        o_insn = {4'b0, w_offLwsp, 5'd2, 3'b010, w_rd, 7'b0000011};
        o_ill  = (w_rd == 5'd0);
      end
      5'b10_100: begin
        if (!i_hw[12]) begin
          if (w_rs2 == 5'd0) begin
            o_insn = {12'b0, w_rd, 3'b000, 5'd0, 7'b1100111};
            o_ill  = (w_rd == 5'd0);
          end else begin
            o_insn = {7'b0, w_rs2, 5'd0, 3'b000, w_rd, 7'b0110011};
          end
        end else if (w_rs2 == 5'd0) begin
          o_insn = (w_rd == 5'd0) ? 32'h0010_0073 : {12'b0, w_rd, 3'b000, 5'd1, 7'b1100111};
        end else begin
          o_insn = {7'b0, w_rs2, w_rd, 3'b000, w_rd, 7'b0110011};
        end
      end
      5'b10_110: o_insn = {4'b0, w_offSwsp[7:5], w_rs2, 5'd2, 3'b010, w_offSwsp[4:0], 7'b0100011};
      default:   o_ill  = 1'b1;
    endcase
    if (!ISA_MASK[2]) o_ill = 1'b1;
  end

endmodule

// File: rtl/boa_insn_align.sv
// Fetch realignment buffer: slices 32-bit fetch words into 16/32-bit instructions.
// Compressed support and halfword alignment are enabled by BOA_INSN_ALIGN_RVC_EN.
module boa_insn_align
  import boa_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] ISA_MASK = 32'hffff_ffff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc,
  output logic        out_comp,
  output logic        out_ill
);

  logic [HW_DEPTH-1:0][15:0] r_buf, w_buf_nxt;
  logic [2:0]                r_cnt, w_cnt_nxt;
  logic [31:0]               r_pc, w_pc_nxt;
  align_state_t              r_state, w_state_nxt, w_flush_state;
  logic                      w_is32, w_push, w_pop, w_pop1;
  logic                      w_unused;

  assign w_is32 = insn_is32(r_buf[0][1:0]);

`ifdef BOA_INSN_ALIGN_RVC_EN
  localparam align_state_t RESET_STATE = RESET_PC[1] ? ALIGN : RUN;

  logic [31:0] w_decInsn;
  logic        w_decIll;

  boa_insn_decomp #(.ISA_MASK(ISA_MASK)) u_decomp (
    .i_hw   (r_buf[0]),
    .o_insn (w_decInsn),
    .o_ill  (w_decIll)
  );

  // A lone 32-bit head halfword waits for its upper half to arrive.
  assign out_valid     = !flush & ((r_cnt >= 3'd2) | ((r_cnt == 3'd1) & !w_is32));
  assign out_insn      = w_is32 ? {r_buf[1], r_buf[0]} : w_decInsn;
  assign out_comp      = (r_cnt != 3'd0) & !w_is32;
  assign out_ill       = (r_cnt != 3'd0) & !w_is32 & w_decIll;
  assign w_pop1        = !w_is32;
  assign w_flush_state = flush_addr[1] ? ALIGN : RUN;
  assign w_unused      = flush_addr[0];
`else
  localparam align_state_t RESET_STATE = RUN;

  assign out_valid     = !flush & (r_cnt >= 3'd2);
  assign out_insn      = {r_buf[1], r_buf[0]};
  assign out_comp      = 1'b0;
  assign out_ill       = (r_cnt != 3'd0) & !w_is32;
  assign w_pop1        = 1'b0;
  assign w_flush_state = RUN;
  assign w_unused      = ^{flush_addr[0], ISA_MASK};
`endif

  assign in_ready = !flush & (r_cnt <= 3'd2);
  assign w_push   = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;
  assign out_pc   = r_pc;

  // Pop shifts the buffer down first; a push then appends at the new tail.
  always_comb begin
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
    if (flush) begin
      w_cnt_nxt   = 3'd0;
      w_pc_nxt    = {flush_addr[31:1], 1'b0};
      w_state_nxt = w_flush_state;
    end else begin
      if (w_pop) begin
        if (w_pop1) begin
          w_buf_nxt = {16'h0000, r_buf[3:1]};
          w_cnt_nxt = r_cnt - 3'd1;
          w_pc_nxt  = r_pc + 32'd2;
        end else begin
          w_buf_nxt = {32'h0000_0000, r_buf[3:2]};
          w_cnt_nxt = r_cnt - 3'd2;
          w_pc_nxt  = r_pc + 32'd4;
        end
      end
      if (w_push) begin
        if (r_state == ALIGN) begin
          w_buf_nxt[w_cnt_nxt[1:0]] = in_data[31:16];
          w_cnt_nxt                 = w_cnt_nxt + 3'd1;
          w_state_nxt               = RUN;
        end else begin
          w_buf_nxt[w_cnt_nxt[1:0]]        = in_data[15:0];
          w_buf_nxt[w_cnt_nxt[1:0] + 2'd1] = in_data[31:16];
          w_cnt_nxt                        = w_cnt_nxt + 3'd2;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf   <= '0;
      r_cnt   <= 3'd0;
      r_pc    <= RESET_PC;
      r_state <= RESET_STATE;
    end else begin
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
    end
  end

endmodule

// File: tb/tb_boa_insn_align.sv
// Directed self-checking bench for boa_insn_align; covers the default build and,
// when BOA_INSN_ALIGN_RVC_EN is defined, the compressed/straddle/align cases.
module tb_boa_insn_align;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] flushAddr;
   logic        inValid;
   logic        inReady;
   logic [31:0] inData;
   logic        outValid;
   logic        outReady;
   logic [31:0] outInsn;
   logic [31:0] outPc;
   logic        outComp;
   logic        outIll;

   int checks = 0;
   int errors = 0;

   boa_insn_align dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .flush_addr (flushAddr),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_data    (inData),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_insn   (outInsn),
      .out_pc     (outPc),
      .out_comp   (outComp),
      .out_ill    (outIll)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not reach its end");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive all DUT inputs at once
   task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic ready,
                                input logic fl, input logic [31:0] fAddr);
      inValid   = valid;
      inData    = data;
      outReady  = ready;
      flush     = fl;
      flushAddr = fAddr;
   endtask

   // Advance past the next rising edge and let outputs settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full output bundle check for a presented instruction
   task automatic checkInsn(input string tag, input logic [31:0] insn, input logic [31:0] pc,
                            input logic comp, input logic ill);
      checkOutput({tag, ".valid"}, {31'b0, outValid}, 32'd1);
      checkOutput({tag, ".insn"}, outInsn, insn);
      checkOutput({tag, ".pc"}, outPc, pc);
      checkOutput({tag, ".comp"}, {31'b0, outComp}, {31'b0, comp});
      checkOutput({tag, ".ill"}, {31'b0, outIll}, {31'b0, ill});
   endtask

   // Linear sequence of directed steps
   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #3;
      checkOutput("reset.valid", {31'b0, outValid}, 32'd0);
      checkOutput("reset.in_ready", {31'b0, inReady}, 32'd1);
      checkOutput("reset.pc", outPc, 32'h0);
      checkOutput("reset.comp", {31'b0, outComp}, 32'd0);
      checkOutput("reset.ill", {31'b0, outIll}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Plain 32-bit instruction
      applyStimulus(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("plain.in_ready", {31'b0, inReady}, 32'd1);
      tick();
      inValid = 1'b0;
      checkInsn("plain", 32'h0000_0013, 32'h0, 1'b0, 1'b0);
      tick();
      checkOutput("plain.after_valid", {31'b0, outValid}, 32'd0);
      checkOutput("plain.after_pc", outPc, 32'h4);

      // Word holding c.nop + c.li a0,1
      applyStimulus(1'b1, 32'h4505_0001, 1'b1, 1'b0, 32'h0);
      tick();
      inValid = 1'b0;
`ifdef BOA_INSN_ALIGN_RVC_EN
      checkInsn("comp0", 32'h0000_0013, 32'h4, 1'b1, 1'b0);
      tick();
      checkInsn("comp1", 32'h0010_0513, 32'h6, 1'b1, 1'b0);
`else
      checkInsn("noRvc", 32'h4505_0001, 32'h4, 1'b0, 1'b1);
`endif
      tick();
      checkOutput("comp.after_valid", {31'b0, outValid}, 32'd0);
      checkOutput("comp.after_pc", outPc, 32'h8);

      // Backpressure: fill to four halfwords, then drain
      applyStimulus(1'b1, 32'h00a0_0093, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("bp.ready_at2", {31'b0, inReady}, 32'd1);
      inData = 32'h0010_0113;
      tick();
      checkOutput("bp.ready_at4", {31'b0, inReady}, 32'd0);
      checkInsn("bp.hold0", 32'h00a0_0093, 32'h8, 1'b0, 1'b0);
      inData = 32'h0030_0213;
      tick();
      checkInsn("bp.hold1", 32'h00a0_0093, 32'h8, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      checkInsn("bp.second", 32'h0010_0113, 32'hc, 1'b0, 1'b0);
      tick();
      checkOutput("bp.drained_valid", {31'b0, outValid}, 32'd0);
      checkOutput("bp.drained_pc", outPc, 32'h10);

      // Flush racing an in and an out handshake
      applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("race.pre_valid", {31'b0, outValid}, 32'd1);
      applyStimulus(1'b1, 32'h0050_0293, 1'b1, 1'b1, 32'h0000_1000);
      #1;
      checkOutput("race.in_ready", {31'b0, inReady}, 32'd0);
      checkOutput("race.out_valid", {31'b0, outValid}, 32'd0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("race.after_valid", {31'b0, outValid}, 32'd0);
      checkOutput("race.after_pc", outPc, 32'h1000);
      checkOutput("race.after_ready", {31'b0, inReady}, 32'd1);
      applyStimulus(1'b1, 32'h0020_0193, 1'b1, 1'b0, 32'h0);
      tick();
      inValid = 1'b0;
      checkInsn("race.next", 32'h0020_0193, 32'h1000, 1'b0, 1'b0);
      tick();
      checkOutput("race.next_pc", outPc, 32'h1004);

`ifdef BOA_INSN_ALIGN_RVC_EN
      // Straddling 32-bit instruction across two words with an idle gap
      applyStimulus(1'b1, 32'h0513_0001, 1'b1, 1'b0, 32'h0);
      tick();
      inValid = 1'b0;
      checkInsn("strad.nop", 32'h0000_0013, 32'h1004, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("strad.gap_valid", {31'b0, outValid}, 32'd0);
      end
      applyStimulus(1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0);
      tick();
      inValid = 1'b0;
      checkInsn("strad.li", 32'h0010_0513, 32'h1006, 1'b0, 1'b0);
      tick();
      checkInsn("illegal", 32'h0000_0000 | outInsn, 32'h100a, 1'b1, 1'b1);
      tick();
      checkOutput("illegal.after_pc", outPc, 32'h100c);
      checkOutput("illegal.after_valid", {31'b0, outValid}, 32'd0);

      // Misaligned flush drops the low halfword of the next word
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1002);
      tick();
      applyStimulus(1'b1, 32'h4505_0001, 1'b1, 1'b0, 32'h0);
      tick();
      inValid = 1'b0;
      checkInsn("align", 32'h0010_0513, 32'h1002, 1'b1, 1'b0);
      tick();
      checkOutput("align.after_valid", {31'b0, outValid}, 32'd0);
      checkOutput("align.after_pc", outPc, 32'h1004);
`endif

      // Asynchronous reset mid-stream discards the buffer without a clock edge
      applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
      tick();
      inValid = 1'b0;
      checkOutput("arst.pre_valid", {31'b0, outValid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst.valid", {31'b0, outValid}, 32'd0);
      checkOutput("arst.pc", outPc, 32'h0);
      checkOutput("arst.in_ready", {31'b0, inReady}, 32'd1);
      tick();
      rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
